trade_frame_codec: RTL and testbench

//  Framed, multi-symbol UART protocol codec between uart_txrx and per-symbol trading cores.
//  RX side: parses sync/symbol/price/checksum frames from the byte stream and emits one price

---
 rtl/trade_frame_codec.sv | 168 ++++++++++++++++
 tb/tb_trade_frame_codec.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_frame_codec.sv
// trade_frame_codec: UART frame parser emitting price strobes, plus FIFO-backed checksummed response framer.
module trade_frame_codec #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int PRICE_BYTES = 4,
  parameter int NUM_SYMBOLS = 4,
  parameter int SYM_W = $clog2(NUM_SYMBOLS),
  parameter int RSP_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_BYTES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [8*PRICE_BYTES-1:0] price_out,
  output logic [SYM_W-1:0]         price_sym,
  output logic                     price_valid,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [SYM_W-1:0]         act_sym,
  input  logic [1:0]               act_action,
  input  logic [15:0]              act_rsi,
  output logic [15:0]              err_cksum_cnt,
  output logic [15:0]              err_frame_cnt,
  output logic [15:0]              drop_cnt
);
  localparam longint TO_CYC = longint'(TIMEOUT_BYTES) * 10 * CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int PW = 8 * PRICE_BYTES;
  localparam int BW = PRICE_BYTES > 1 ? $clog2(PRICE_BYTES) : 1;
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int EW = SYM_W + 18;

  typedef enum logic [1:0] {R_SYNC, R_SYM, R_PRICE, R_CK} r_state_t;
  typedef enum logic [2:0] {T_IDLE, T_SYNC, T_SYM, T_ACT, T_RSIL, T_RSIH, T_CK} t_state_t;

  r_state_t r_st, r_cur, r_nx;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] acc;
  logic [7:0] ck_acc;
  logic [SYM_W-1:0] sym_r;
  logic bad, to_hit, ck_fire, emit, ck_err, fr_err;

  always_ff @(posedge clk) r_st <= rst ? R_SYNC : r_nx;

  // a timeout retires the frame first, so a byte arriving in that cycle is judged from R_SYNC
  always_comb begin
    to_hit = r_st != R_SYNC && to_cnt == TW'(TO_CYC);
    r_cur = to_hit ? R_SYNC : r_st;
    r_nx = !rx_ready ? r_cur :
           r_cur == R_SYNC ? (rx_data == SYNC_BYTE ? R_SYM : R_SYNC) :
           r_cur == R_SYM ? R_PRICE :
           r_cur == R_PRICE ? (bcnt == BW'(PRICE_BYTES - 1) ? R_CK : R_PRICE) : R_SYNC;
  end

  always_comb begin
    ck_fire = rx_ready && r_cur == R_CK;
    emit = ck_fire && rx_data == ck_acc && !bad;
    ck_err = ck_fire && rx_data != ck_acc;
    fr_err = to_hit || (ck_fire && rx_data == ck_acc && bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      bcnt <= '0;
      acc <= '0;
      ck_acc <= '0;
      sym_r <= '0;
      bad <= 1'b0;
      price_out <= '0;
      price_sym <= '0;
      price_valid <= 1'b0;
      err_cksum_cnt <= '0;
      err_frame_cnt <= '0;
    end else begin
      to_cnt <= rx_ready ? '0 : to_cnt + TW'(to_cnt != TW'(TO_CYC));
      if (rx_ready && r_cur == R_SYM) begin
        sym_r <= rx_data[SYM_W-1:0];
        bad <= {1'b0, rx_data} >= 9'(NUM_SYMBOLS);
        ck_acc <= rx_data;
        bcnt <= '0;
      end
      if (rx_ready && r_cur == R_PRICE) begin
        acc <= (acc << 8) | PW'(rx_data);
        ck_acc <= ck_acc ^ rx_data;
        bcnt <= bcnt + BW'(1);
      end
      price_valid <= emit;
      if (emit) begin
        price_out <= acc;
        price_sym <= sym_r;
      end
      err_cksum_cnt <= err_cksum_cnt + 16'(ck_err && err_cksum_cnt != 16'hFFFF);
      err_frame_cnt <= err_frame_cnt + 16'(fr_err && err_frame_cnt != 16'hFFFF);
    end
  end

  t_state_t t_st, t_nx;
  logic [EW-1:0] mem [RSP_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic full, push, pop, issue;
  logic [SYM_W-1:0] h_sym;
  logic [1:0] h_act;
  logic [15:0] h_rsi;
  logic [7:0] t_byte;

  assign act_ready = !full;

  always_comb begin
    push = act_valid && !full;
    pop = issue && t_st == T_CK;
    cnt_nx = cnt + (AW+1)'(push) - (AW+1)'(pop);
    {h_sym, h_act, h_rsi} = mem[rp];
  end

  always_ff @(posedge clk) if (push) mem[wp] <= {act_sym, act_action, act_rsi};

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt_nx;
      full <= cnt_nx == (AW+1)'(RSP_DEPTH);
      drop_cnt <= drop_cnt + 16'(act_valid && full && drop_cnt != 16'hFFFF);
    end
  end

  always_ff @(posedge clk) t_st <= rst ? T_IDLE : t_nx;

  always_comb begin
    t_nx = t_st == T_IDLE ? (cnt != '0 ? T_SYNC : T_IDLE) :
           !issue ? t_st :
           t_st == T_CK ? T_IDLE : t_state_t'(t_st + 3'd1);
  end

  always_comb begin
    issue = t_st != T_IDLE && !tx_busy && !tx_start;
    t_byte = t_st == T_SYNC ? SYNC_BYTE :
             t_st == T_SYM ? 8'(h_sym) :
             t_st == T_ACT ? {6'b0, h_act} :
             t_st == T_RSIL ? h_rsi[7:0] :
             t_st == T_RSIH ? h_rsi[15:8] :
             8'(h_sym) ^ {6'b0, h_act} ^ h_rsi[7:0] ^ h_rsi[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_start <= issue;
      if (issue) tx_data <= t_byte;
    end
  end
endmodule

// File: tb/tb_trade_frame_codec.sv
// tb_trade_frame_codec: randomized frame traffic against a frame-level reference model with queued expectations.
module tb_trade_frame_codec;
  localparam int TO_CYC = 300;

  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_ready = 0;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy = 0;
  logic [31:0] price_out;
  logic [1:0] price_sym;
  logic price_valid;
  logic act_valid = 0;
  logic act_ready;
  logic [1:0] act_sym = 0, act_action = 0;
  logic [15:0] act_rsi = 0;
  logic [15:0] err_cksum_cnt, err_frame_cnt, drop_cnt;

  typedef struct packed {logic [1:0] sym; logic [31:0] price;} px_t;
  px_t exp_price[$];
  logic [7:0] exp_tx[$];
  int total = 0, bad = 0, m_ck = 0, m_fr = 0, m_drop = 0, tx_seen = 0;
  logic [31:0] last_price = 0;
  logic [1:0] last_sym = 0;
  logic hold = 0, prev_busy = 0, prev_start = 0;

  always #5 clk = ~clk;

  trade_frame_codec #(.CLK_FREQ(96000), .BAUD_RATE(9600)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .price_out(price_out), .price_sym(price_sym),
    .price_valid(price_valid), .act_valid(act_valid), .act_ready(act_ready), .act_sym(act_sym),
    .act_action(act_action), .act_rsi(act_rsi), .err_cksum_cnt(err_cksum_cnt),
    .err_frame_cnt(err_frame_cnt), .drop_cnt(drop_cnt));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    prev_busy <= tx_busy;
    prev_start <= tx_start;
  end

  // scoreboard monitor
  always @(negedge clk) if (!rst) begin
    px_t e;
    if (price_valid) begin
      if (exp_price.size() == 0) begin
        total++; bad++;
        $display("FAIL price_unexpected got=%0h want=none", price_out);
      end else begin
        e = exp_price.pop_front();
        chk("price_out", price_out, e.price);
        chk("price_sym", price_sym, e.sym);
      end
    end
    if (tx_start) begin
      tx_seen++;
      chk("tx_gap", {prev_busy, prev_start}, 0);
      if (exp_tx.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_unexpected got=%0h want=none", tx_data);
      end else chk("tx_data", tx_data, exp_tx.pop_front());
    end
  end

  // UART transmitter model
  initial forever begin
    @(negedge clk);
    if (hold) tx_busy = 1;
    else if (tx_start) begin
      tx_busy = 1;
      repeat ($urandom_range(2, 6)) @(negedge clk);
      tx_busy = 0;
    end else tx_busy = 0;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] sym, input logic [31:0] price, input logic [7:0] ckx, input int sym_gap);
    logic [7:0] ck = sym ^ price[31:24] ^ price[23:16] ^ price[15:8] ^ price[7:0];
    if (ckx != 0) m_ck++;
    else if (sym >= 4) m_fr++;
    else begin
      exp_price.push_back(px_t'({sym[1:0], price}));
      last_price = price;
      last_sym = sym[1:0];
    end
    send_byte(8'hA5, $urandom_range(0, 4));
    send_byte(sym, sym_gap);
    for (int i = 0; i < 4; i++) send_byte(price[31-8*i -: 8], $urandom_range(0, 4));
    send_byte(ck ^ ckx, $urandom_range(0, 4));
  endtask

  function automatic void exp_frame(input logic [1:0] s, input logic [1:0] a, input logic [15:0] r);
    exp_tx.push_back(8'hA5);
    exp_tx.push_back({6'b0, s});
    exp_tx.push_back({6'b0, a});
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    exp_tx.push_back({6'b0, s} ^ {6'b0, a} ^ r[7:0] ^ r[15:8]);
  endfunction

  task automatic push_act(input logic [1:0] s, input logic [1:0] a, input logic [15:0] r);
    int w = 0;
    @(negedge clk);
    while (!act_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!act_ready) begin
      total++; bad++;
      $display("FAIL act_ready_wait got=0 want=1");
      return;
    end
    act_valid = 1; act_sym = s; act_action = a; act_rsi = r;
    exp_frame(s, a, r);
    @(negedge clk);
    act_valid = 0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_tx.size() != 0 || exp_price.size() != 0) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_tx", exp_tx.size(), 0);
  endtask

  task automatic checkpoint(input string tag);
    repeat (10) @(negedge clk);
    chk({tag, "_cksum_cnt"}, err_cksum_cnt, m_ck);
    chk({tag, "_frame_cnt"}, err_frame_cnt, m_fr);
    chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
    chk({tag, "_price_pending"}, exp_price.size(), 0);
    chk({tag, "_price_hold"}, price_out, last_price);
    chk({tag, "_sym_hold"}, price_sym, last_sym);
  endtask

  initial begin
    logic [7:0] b;
    int base, w;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_price_valid", price_valid, 0);
    chk("rst_price_out", price_out, 0);
    chk("rst_act_ready", act_ready, 1);
    chk("rst_err_cksum", err_cksum_cnt, 0);
    chk("rst_err_frame", err_frame_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 0;
    send_frame(8'd1, 32'h00002710, 8'h00, 2);
    checkpoint("good");
    send_frame(8'd1, 32'h00002710, 8'h01, 2);
    checkpoint("bad_ck");
    send_frame(8'd3, 32'h12A5A5FF, 8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h13, 1);
    send_frame(8'd7, 32'h00000001, 8'h00, 1);
    checkpoint("bad_sym");
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 2 * TO_CYC);
    m_fr++;
    checkpoint("timeout");
    send_frame(8'd2, 32'hDEADBEEF, 8'h00, TO_CYC - 20);
    checkpoint("near_timeout");
    send_byte(8'hA5, TO_CYC + 20);
    m_fr++;
    send_frame(8'd0, 32'h80000001, 8'h00, 3);
    checkpoint("after_timeout");
    push_act(2'd2, 2'd1, 16'h1B58);
    drain();
    hold = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      act_valid = 1;
      act_sym = 2'(i);
      act_action = 2'(i % 3);
      act_rsi = 16'($urandom);
      if (i < 4) exp_frame(act_sym, act_action, act_rsi);
      else m_drop++;
    end
    @(negedge clk);
    act_valid = 0;
    chk("act_ready_full", act_ready, 0);
    hold = 0;
    drain();
    checkpoint("drop");
    fork
      for (int n = 0; n < 40; n++) begin
        case ($urandom_range(0, 5))
          3: send_frame(8'($urandom_range(0, 3)), $urandom, 8'($urandom_range(1, 255)), $urandom_range(0, 4));
          4: send_frame(8'($urandom_range(4, 255)), $urandom, $urandom_range(0, 1) ? 8'h00 : 8'h5A, $urandom_range(0, 4));
          5: begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
              b = 8'($urandom);
              send_byte(b == 8'hA5 ? 8'h00 : b, $urandom_range(0, 3));
            end
            send_frame(8'($urandom_range(0, 3)), $urandom, 8'h00, $urandom_range(0, 4));
          end
          default: send_frame(8'($urandom_range(0, 3)), $urandom, 8'h00, $urandom_range(0, 4));
        endcase
      end
      for (int n = 0; n < 12; n++) begin
        push_act(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 16'($urandom));
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    join
    drain();
    checkpoint("random");
    push_act(2'd3, 2'd2, 16'hABCD);
    base = tx_seen;
    w = 0;
    while (tx_seen < base + 2 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("mid_frame_reached", tx_seen >= base + 2, 1);
    rst = 1;
    exp_tx.delete();
    exp_price.delete();
    m_ck = 0; m_fr = 0; m_drop = 0;
    last_price = 0; last_sym = 0;
    @(negedge clk);
    chk("rst_mid_tx_start", tx_start, 0);
    chk("rst_mid_act_ready", act_ready, 1);
    @(negedge clk);
    rst = 0;
    repeat (100) @(negedge clk);
    checkpoint("reset_mid");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
